// File: rtl/j_addsize_walker_pkg.sv
// Shared constants and FSM state encoding for the address-size walker.
package j_addsize_walker_pkg;

  localparam int unsigned ADDR_W_DEF = 23;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } walk_state_t;

endpackage

// File: rtl/j_addsize_walker_addsize.sv
// Combinational ADDR_W-bit + 3-bit adder; carry out of the top bit is dropped (modulo wrap).
module j_addsize
  import j_addsize_walker_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_a,
  input  logic [2:0]        i_b,
  output logic [ADDR_W-1:0] o_sum
);

  logic [ADDR_W-2:0] w_c;

  // Bit 0 is a half adder, bits 1-2 full adders, the rest a half-adder carry ripple.
  always_comb begin
    w_c   = '0;
    o_sum = '0;
    o_sum[0] = i_a[0] ^ i_b[0];
    w_c[0]   = i_a[0] & i_b[0];
    for (int unsigned i = 1; i < 3; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i-1];
      w_c[i]   = (i_a[i] & i_b[i]) | (w_c[i-1] & (i_a[i] ^ i_b[i]));
    end
    for (int unsigned i = 3; i < ADDR_W - 1; i++) begin
      o_sum[i] = i_a[i] ^ w_c[i-1];
      w_c[i]   = i_a[i] & w_c[i-1];
    end
    o_sum[ADDR_W-1] = i_a[ADDR_W-1] ^ w_c[ADDR_W-2];
  end

endmodule

// File: rtl/j_addsize_walker.sv
// Sequential address stepper: issues one request per transfer and advances the
// address by the latched transfer size on each acknowledge.
module j_addsize_walker
  import j_addsize_walker_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  xfer_count,
  input  logic [2:0]        size,
  input  logic              ack,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              last,
  output logic              done
);

  walk_state_t       r_state;
  walk_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] w_addr_sum;
  logic              w_load;
  logic              w_step;
  logic              w_rem_one;

  j_addsize #(.ADDR_W(ADDR_W)) u_addsize (
    .i_a   (r_addr),
    .i_b   (r_size),
    .o_sum (w_addr_sum)
  );

  assign w_rem_one = (r_rem == CNT_W'(1));

  // abort outranks ack in RUN; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (xfer_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (ack) begin
          w_step = 1'b1;
          if (w_rem_one) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req  = (r_state == ST_RUN);
    busy = (r_state == ST_RUN) || (r_state == ST_DONE);
    last = req & w_rem_one;
    done = (r_state == ST_DONE);
    addr = r_addr;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_addr <= start_addr;
        r_rem  <= xfer_count;
        r_size <= size;
      end else if (w_step) begin
        r_addr <= w_addr_sum;
        r_rem  <= r_rem - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_j_addsize_walker.sv
// Self-checking bench for j_addsize_walker: vector table, corner sequences, random walks.
module tb_j_addsize_walker;

  logic        sys_clk = 1'b0;
  logic        reset, start, abort, ack;
  logic [22:0] start_addr, addr;
  logic [15:0] xfer_count;
  logic [2:0]  size;
  logic        req, busy, last, done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  j_addsize_walker #(.ADDR_W(23), .CNT_W(16)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .xfer_count (xfer_count),
    .size       (size),
    .ack        (ack),
    .req        (req),
    .addr       (addr),
    .busy       (busy),
    .last       (last),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [22:0] sa;
    int unsigned cnt;
    logic [2:0]  sz;
    logic [22:0] exp_fin;
  } vec_t;

  vec_t tbl [7];

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: transfer k sits at (sa + k*sz) mod 2^23; last on k==cnt-1; done after final ack.
  task automatic walk(input logic [22:0] sa, input int unsigned cnt, input logic [2:0] sz,
                      input int unsigned ack_pct, output logic [22:0] fin);
    int unsigned k   = 0;
    int unsigned cyc = 0;
    logic [22:0] ea;
    start_addr = sa; xfer_count = cnt[15:0]; size = sz; start = 1'b1;
    tick;
    start = 1'b0;
    while (k < cnt && cyc < 64 * cnt + 16) begin
      ea = 23'((64'(sa) + 64'(k) * 64'(sz)) % (64'd1 << 23));
      chk("req_run", req, 1);
      chk("busy_run", busy, 1);
      chk("addr_run", addr, ea);
      chk("last_run", last, (k == cnt - 1) ? 1 : 0);
      chk("done_run", done, 0);
      ack = ($urandom_range(99) < ack_pct);
      tick;
      if (ack) k++;
      cyc++;
    end
    ack = 1'b0;
    if (k < cnt) chk("walk_timeout", k, cnt);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("req_done", req, 0);
    fin = addr;
    tick;
    chk("done_clr", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [22:0] fin;
    tbl[0] = '{23'h000100, 3, 3'd4, 23'h00010C};
    tbl[1] = '{23'h7FFFFE, 2, 3'd4, 23'h000006};
    tbl[2] = '{23'h000040, 4, 3'd0, 23'h000040};
    tbl[3] = '{23'h123456, 1, 3'd7, 23'h12345D};
    tbl[4] = '{23'h7FFFFF, 1, 3'd1, 23'h000000};
    tbl[5] = '{23'h0000F8, 2, 3'd7, 23'h000106};
    tbl[6] = '{23'h2AAAAA, 0, 3'd5, 23'h2AAAAA};

    reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    start_addr = '0; xfer_count = '0; size = '0;
    tick; tick;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) begin
      walk(tbl[i].sa, tbl[i].cnt, tbl[i].sz, 100, fin);
      chk("tbl_final_addr", fin, tbl[i].exp_fin);
    end

    // abort together with ack on the 2nd transfer
    start_addr = 23'h001000; xfer_count = 16'd5; size = 3'd2; start = 1'b1;
    tick; start = 1'b0;
    ack = 1'b1; tick;
    chk("abt_addr1", addr, 23'h001002);
    abort = 1'b1; tick;
    abort = 1'b0; ack = 1'b0;
    chk("abt_req", req, 0);
    chk("abt_busy", busy, 0);
    chk("abt_addr", addr, 23'h001002);
    chk("abt_done", done, 0);
    tick;
    chk("abt_done2", done, 0);

    // start mid-walk with new values is ignored
    start_addr = 23'h000200; xfer_count = 16'd3; size = 3'd1; start = 1'b1;
    tick; start = 1'b0;
    chk("mid_addr0", addr, 23'h000200);
    start_addr = 23'h000555; xfer_count = 16'd9; size = 3'd7; start = 1'b1; ack = 1'b1;
    tick;
    chk("mid_addr1", addr, 23'h000201);
    start = 1'b0;
    tick;
    chk("mid_addr2", addr, 23'h000202);
    chk("mid_last", last, 1);
    tick; ack = 1'b0;
    chk("mid_done", done, 1);
    chk("mid_fin", addr, 23'h000203);
    tick;

    // start and abort together in IDLE: start wins
    start_addr = 23'h000010; xfer_count = 16'd1; size = 3'd3; start = 1'b1; abort = 1'b1;
    tick; start = 1'b0; abort = 1'b0;
    chk("sa_req", req, 1);
    chk("sa_last", last, 1);
    ack = 1'b1; tick; ack = 1'b0;
    chk("sa_done", done, 1);
    chk("sa_fin", addr, 23'h000013);
    tick;

    // ack in IDLE is ignored; post-walk address stays readable
    ack = 1'b1; tick; tick; ack = 1'b0;
    chk("idle_ack_req", req, 0);
    chk("idle_ack_addr", addr, 23'h000013);
    chk("idle_ack_done", done, 0);

    // async reset mid-walk
    start_addr = 23'h003000; xfer_count = 16'd4; size = 3'd4; start = 1'b1;
    tick; start = 1'b0;
    ack = 1'b1; tick; ack = 1'b0;
    chk("ar_pre_req", req, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_req", req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", addr, 0);
    reset = 1'b0;
    tick;
    chk("ar_done", done, 0);
    chk("ar_busy2", busy, 0);

    for (int r = 0; r < 25; r++) begin
      walk(23'($urandom), $urandom_range(6), 3'($urandom_range(7)), 60, fin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
